// File: rtl/intc_pkg.sv
// Shared definitions for the interrupt controller: FSM state encoding,
// the timer's fixed source index and the default sizing constants.
package intc_pkg;

    localparam int NUM_SRC_DEF = 4;
    localparam int CAUSE_W_DEF = 2;
    localparam int CAUSE_TIMER = 0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_e;

endpackage

// File: rtl/intc_if.sv
// Core-side interrupt port: enables and the ack/eoi handshake in one
// direction, irq plus cause code in the other.
interface intc_if #(
    parameter int NUM_SRC = intc_pkg::NUM_SRC_DEF,
    parameter int CAUSE_W = intc_pkg::CAUSE_W_DEF
) ();

    logic               irq_en;
    logic [NUM_SRC-1:0] mask;
    logic               irq_ack;
    logic               eoi;
    logic               irq;
    logic [CAUSE_W-1:0] irq_cause;

    // The core drives enables and the handshake.
    modport master (
        output irq_en, mask, irq_ack, eoi,
        input  irq, irq_cause
    );

    // The controller presents the request.
    modport slave (
        input  irq_en, mask, irq_ack, eoi,
        output irq, irq_cause
    );

endinterface

// File: rtl/intc_edge_detect.sv
// Registered rising-edge detector. The sample register clears to 0, so a
// source that is already high when reset is released counts as an edge.
module intc_edge_detect #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] rise
);

    logic [WIDTH-1:0] prev;

    // NOTE: clocked state uses non-blocking assignments so that every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            prev <= '0;
        end else begin
            prev <= level;
        end
    end

    assign rise = level & ~prev;

endmodule

// File: rtl/interrupt_controller.sv
// Latches timer and external request edges, presents the highest-priority enabled one
// to the core, and freezes or restarts the quantum timer around the handler.
// Optional build macro: INTC_ACK_TIMEOUT_EN abandons an unacknowledged request.
module interrupt_controller
    import intc_pkg::*;
#(
    parameter int NUM_SRC     = NUM_SRC_DEF,
    parameter int CAUSE_W     = CAUSE_W_DEF,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               sigint,
    input  logic [NUM_SRC-2:0] ext_req,
    intc_if.slave              core,
    output logic [NUM_SRC-1:0] pending,
    output logic               timer_stop,
    output logic               timer_reset
);

    localparam logic [1:0] ST_IDLE    = IDLE;
    localparam logic [1:0] ST_REQ     = REQ;
    localparam logic [1:0] ST_SERVICE = SERVICE;

    if ((2 ** CAUSE_W) < NUM_SRC) begin : g_bad_cause_w
        $error("interrupt_controller: CAUSE_W too narrow for NUM_SRC");
    end
    if ((ACK_TIMEOUT < 1) || (ACK_TIMEOUT > 255)) begin : g_bad_timeout
        $error("interrupt_controller: ACK_TIMEOUT must fit the 8-bit counter");
    end

    logic [1:0]         state;
    logic [CAUSE_W-1:0] cause;
    logic               irq_q;
    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] active;
    logic [NUM_SRC-1:0] clr;
    logic [CAUSE_W-1:0] sel;
    logic               ack_take;
    logic               ack_expire;

    intc_edge_detect #(
        .WIDTH (NUM_SRC)
    ) u_edge (
        .clock (clock),
        .reset (reset),
        .level ({ext_req, sigint}),
        .rise  (rise)
    );

    assign active = pending & core.mask;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        sel = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (active[i]) begin
                sel = CAUSE_W'(i);
            end
        end
    end

    assign ack_take = (state == ST_REQ) && core.irq_ack;
    assign clr      = ack_take ? (NUM_SRC'(1) << cause) : '0;

    // A fresh edge in the same cycle as the clear keeps the bit set.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~clr) | rise;
        end
    end

`ifdef INTC_ACK_TIMEOUT_EN
    logic [7:0] ack_cnt;

    assign ack_expire = (state == ST_REQ) && !core.irq_ack
                        && (ack_cnt == 8'(ACK_TIMEOUT - 1));

    // Held at zero outside REQ, so each REQ entry starts a fresh count.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ack_cnt <= '0;
        end else if (state == ST_REQ) begin
            ack_cnt <= ack_cnt + 8'd1;
        end else begin
            ack_cnt <= '0;
        end
    end
`else
    assign ack_expire = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            cause       <= CAUSE_W'(CAUSE_TIMER);
            irq_q       <= 1'b0;
            timer_stop  <= 1'b0;
            timer_reset <= 1'b0;
        end else begin
            timer_reset <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (core.irq_en && (|active)) begin
                        state <= ST_REQ;
                        cause <= sel;
                        irq_q <= 1'b1;
                    end
                end
                ST_REQ: begin
                    // No withdrawal: only ack (or the optional timeout) ends REQ.
                    if (core.irq_ack) begin
                        state      <= ST_SERVICE;
                        irq_q      <= 1'b0;
                        timer_stop <= 1'b1;
                    end else if (ack_expire) begin
                        state <= ST_IDLE;
                        irq_q <= 1'b0;
                    end
                end
                ST_SERVICE: begin
                    if (core.eoi) begin
                        state       <= ST_IDLE;
                        timer_stop  <= 1'b0;
                        timer_reset <= 1'b1;
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    irq_q      <= 1'b0;
                    timer_stop <= 1'b0;
                end
            endcase
        end
    end

    assign core.irq       = irq_q;
    assign core.irq_cause = cause;

endmodule

// File: doc/interrupt_controller.md
Name: interrupt_controller

Overview:
- Sits directly downstream of the quantum timer and upstream of the CPU core's trap logic.
- Converts the timer's level sigint, plus external device requests, into latched pending bits.
- Selects the highest-priority enabled source and raises one irq to the core with a cause code, under an ack / end-of-interrupt handshake.
- Drives the timer's stop/reset inputs: the quantum is frozen while a handler runs and restarted on return.

Parameters:
- NUM_SRC, 4, total sources; index 0 is the timer and has the highest priority; indices 1..NUM_SRC-1 are external.
- CAUSE_W, 2, width of the cause code; must satisfy 2**CAUSE_W >= NUM_SRC.
- ACK_TIMEOUT, 255, cycles in REQ before abandoning the request (used only with the optional feature).

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- sigint  in  1  timer request; a level that stays high until the timer is reset.
- ext_req  in  NUM_SRC-1  external device requests; level inputs.
- irq_en  in  1  global interrupt enable from the core status register.
- mask  in  NUM_SRC  per-source enable; 1 means enabled.
- irq_ack  in  1  core accepts the presented interrupt.
- eoi  in  1  core returns from the handler.
- irq  out  1  interrupt request to the core.
- irq_cause  out  CAUSE_W  index of the presented source.
- pending  out  NUM_SRC  latched pending bits.
- timer_stop  out  1  held high while a handler is in service.
- timer_reset  out  1  one-cycle pulse that restarts the quantum.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; irq=0, irq_cause=0, pending=0, timer_stop=0, timer_reset=0.
  - Previous-sample registers for edge detection are cleared to 0, so a source already high at release registers as a rising edge.
- Edge detection: each source (sigint is source 0) is registered once per clock; a 0->1 transition sets pending[i] on that edge.
  - Masked sources still latch pending; the mask affects selection only.
- Selection: the lowest index among (pending & mask) wins; this is combinational and fed into a registered cause.
- FSM:
  - IDLE: if irq_en=1 and |(pending & mask), then cause <= selected index and go to REQ.
  - REQ: irq=1 and irq_cause=cause, both stable. On irq_ack: clear pending[cause] and go to SERVICE. irq stays high until ack even if irq_en or mask drops; there is no withdrawal.
  - SERVICE: irq=0 and timer_stop=1. On eoi: go to IDLE and pulse timer_reset=1 for exactly one cycle.
- Latency: edge sampled at rising edge k sets pending; the FSM enters REQ at k+1 and irq is high from k+1. In SERVICE, eoi sampled at edge m gives IDLE plus timer_reset high during cycle m..m+1, and the next REQ no earlier than m+1.
- Boundary conditions:
  - A new edge on source i in the same cycle as its clear: set wins, pending[i] stays 1.
  - Edges arriving during REQ or SERVICE latch normally; no request is lost.
  - irq_ack outside REQ and eoi outside SERVICE are ignored.
  - irq_ack and eoi asserted together in REQ: only the ack acts.
  - Asynchronous reset mid-SERVICE: outputs return to reset values immediately, so timer_stop drops. The timer then free-runs from its current count; no timer_reset pulse is generated.
- All outputs are registered.

Optional Feature:
- Macro INTC_ACK_TIMEOUT_EN.
- Defined: an 8-bit counter runs while in REQ. If it reaches ACK_TIMEOUT with no irq_ack:
  - return to IDLE with irq=0 for at least one cycle;
  - pending[cause] stays set, so the request is re-presented later;
  - the counter clears on every REQ entry.
- Undefined: REQ waits indefinitely for irq_ack and no counter logic is synthesised.

Decomposition:
- Package intc_pkg holds:
  - state enum {IDLE, REQ, SERVICE};
  - CAUSE_TIMER = 0;
  - default NUM_SRC and CAUSE_W constants.
- One sub-module: intc_edge_detect (NUM_SRC-wide registered rising-edge detector, asynchronous active-low reset). The priority encoder stays inline.

Test Plan:
- Release reset with sigint=0; at cycle 10 raise sigint with mask=4'b1111, irq_en=1 -> pending[0]=1 after 1 edge, irq=1 with irq_cause=0 after 2 edges; ack -> pending[0]=0, timer_stop=1; eoi -> timer_stop=0, timer_reset high exactly 1 cycle.
- ext_req[0] (source 1) and ext_req[2] (source 3) rise in the same cycle -> irq_cause=1 first; after ack+eoi, irq_cause=3 is presented.
- mask=4'b1110 with sigint rising -> pending[0]=1, irq stays 0; set mask[0]=1 -> irq with cause 0 within 2 cycles.
- While in SERVICE, ext_req[1] (source 2) rises -> pending[2]=1 and irq stays 0; on eoi -> REQ with cause 2 next cycle; an eoi driven while in REQ is ignored.
- Assert reset mid-SERVICE -> irq=0, timer_stop=0, pending=0 immediately without a clock edge; after release with sigint still high -> pending[0]=1 on the first edge.
- With INTC_ACK_TIMEOUT_EN and ACK_TIMEOUT=5, hold irq_ack=0 -> irq drops after 5 cycles in REQ, pending bit retained, REQ re-entered and irq high again.
